// File: rtl/addsub_issuer.sv
// Issues add/subtract commands to an external registered adder and collects results in order.
// Issue is throttled so every in-flight operation always has a free result-buffer slot.
module addsub_issuer #(
  parameter int unsigned W      = 32,
  parameter int unsigned CDEPTH = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_mode,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_mode,
  input  logic [W-1:0] add_sum,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_mode,
  output logic         busy
);

  localparam int unsigned PW    = $clog2(CDEPTH);
  localparam logic [PW:0] CFull = (PW+1)'(CDEPTH);

  logic [W-1:0]      ca_mem [CDEPTH];
  logic [W-1:0]      cb_mem [CDEPTH];
  logic [CDEPTH-1:0] cm_mem;
  logic [W-1:0]      rs_mem [4];
  logic [3:0]        rm_mem;

  logic [PW-1:0] cwptr_q, cwptr_d, crptr_q, crptr_d;
  logic [PW:0]   ccount_q, ccount_d;
  logic [W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic          add_mode_q, add_mode_d;
  logic          v1_q, v1_d, m1_q, m1_d, v2_q, v2_d, m2_q, m2_d;
  logic [1:0]    rwptr_q, rwptr_d, rrptr_q, rrptr_d;
  logic [2:0]    rcount_q, rcount_d;

  logic       push, issue, capture, rpop;
  logic [3:0] inflight;

  assign cmd_ready = ccount_q < CFull;
  assign push      = cmd_valid & cmd_ready;
  // Results already buffered plus those still in the adder pipeline must fit in 4 slots.
  assign inflight  = {1'b0, rcount_q} + {3'b000, v1_q} + {3'b000, v2_q};
  assign issue     = (ccount_q != '0) && (inflight < 4'd4);
  assign capture   = v2_q;
  assign rpop      = res_valid & res_ready;

  always_comb begin
    cwptr_d    = cwptr_q + PW'(push);
    crptr_d    = crptr_q + PW'(issue);
    ccount_d   = ccount_q + (PW+1)'(push) - (PW+1)'(issue);
    add_a_d    = issue ? ca_mem[crptr_q] : add_a_q;
    add_b_d    = issue ? cb_mem[crptr_q] : add_b_q;
    add_mode_d = issue ? cm_mem[crptr_q] : add_mode_q;
    v1_d       = issue;
    m1_d       = issue ? cm_mem[crptr_q] : m1_q;
    v2_d       = v1_q;
    m2_d       = m1_q;
    rwptr_d    = rwptr_q + 2'(capture);
    rrptr_d    = rrptr_q + 2'(rpop);
    rcount_d   = rcount_q + 3'(capture) - 3'(rpop);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cwptr_q    <= '0;
      crptr_q    <= '0;
      ccount_q   <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_mode_q <= 1'b0;
      v1_q       <= 1'b0;
      m1_q       <= 1'b0;
      v2_q       <= 1'b0;
      m2_q       <= 1'b0;
      rwptr_q    <= '0;
      rrptr_q    <= '0;
      rcount_q   <= '0;
    end else begin
      cwptr_q    <= cwptr_d;
      crptr_q    <= crptr_d;
      ccount_q   <= ccount_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_mode_q <= add_mode_d;
      v1_q       <= v1_d;
      m1_q       <= m1_d;
      v2_q       <= v2_d;
      m2_q       <= m2_d;
      rwptr_q    <= rwptr_d;
      rrptr_q    <= rrptr_d;
      rcount_q   <= rcount_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      ca_mem[cwptr_q] <= cmd_a;
      cb_mem[cwptr_q] <= cmd_b;
      cm_mem[cwptr_q] <= cmd_mode;
    end
    if (capture) begin
      rs_mem[rwptr_q] <= add_sum;
      rm_mem[rwptr_q] <= m2_q;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_mode  = add_mode_q;
  assign res_valid = rcount_q != '0;
  assign res_sum   = rs_mem[rrptr_q];
  assign res_mode  = rm_mem[rrptr_q];
  assign busy      = (ccount_q != '0) | v1_q | v2_q | (rcount_q != '0);

endmodule
